// File: rtl/alu8_pkg.sv
// Shared definitions for the two-pass 8-bit ALU sequencer: op codes, flag
// positions, FSM states and the per-pass nibble-op mapping.
package alu8_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_CP  = 4'd7;
    localparam logic [3:0] OP_CPL = 4'd8;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        NIB_ADC = 3'd1,
        NIB_SUB = 3'd2,
        NIB_SBC = 3'd3,
        NIB_AND = 3'd4,
        NIB_XOR = 3'd5,
        NIB_OR  = 3'd6,
        NIB_CPL = 3'd7
    } nib_op_e;

    typedef struct packed {
        nib_op_e op;
        logic    cin;
    } nib_ctl_t;

    // The high pass chains the low-pass carry/borrow; the low pass takes 0 or C_in.
    function automatic nib_ctl_t nib_map(input logic [3:0] op, input logic high,
                                         input logic c_in, input logic low_cy);
        nib_ctl_t ctl;
        ctl.op  = NIB_AND;
        ctl.cin = 1'b0;
        case (op)
            OP_ADD:        begin ctl.op = NIB_ADC; ctl.cin = high ? low_cy : 1'b0; end
            OP_ADC:        begin ctl.op = NIB_ADC; ctl.cin = high ? low_cy : c_in; end
            OP_SUB, OP_CP: begin ctl.op = NIB_SBC; ctl.cin = high ? low_cy : 1'b0; end
            OP_SBC:        begin ctl.op = NIB_SBC; ctl.cin = high ? low_cy : c_in; end
            OP_AND:        ctl.op = NIB_AND;
            OP_XOR:        ctl.op = NIB_XOR;
            OP_OR:         ctl.op = NIB_OR;
            OP_CPL:        ctl.op = NIB_CPL;
            default:       ctl.op = NIB_AND;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu8_sequencer_if.sv
// Decode-side bus of the 8-bit ALU sequencer: operation request and result return.
interface alu8_sequencer_if;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] flags_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [3:0] flags_out;
    logic       write_result;

    modport master (
        output start, op, a, b, flags_in,
        input  busy, done, result, flags_out, write_result
    );

    modport slave (
        input  start, op, a, b, flags_in,
        output busy, done, result, flags_out, write_result
    );
endinterface

// File: rtl/alu.sv
// Shared 4-bit nibble ALU; cout is carry for ADC and borrow for SUB/SBC.
module alu (
    input  logic [2:0] op,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] res,
    output logic       cout
);
    logic [4:0] sum;
    logic [4:0] diff;

    // Nibble arithmetic/logic selected by op; code 0 yields zero.
    always_comb begin
        sum  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        diff = {1'b0, x} - {1'b0, y} - {4'b0000, cin};
        res  = 4'h0;
        cout = 1'b0;
        case (op)
            3'd1:    begin res = sum[3:0];  cout = sum[4];  end
            3'd2:    begin res = x - y;     cout = (x < y); end
            3'd3:    begin res = diff[3:0]; cout = diff[4]; end
            3'd4:    res = x & y;
            3'd5:    res = x ^ y;
            3'd6:    res = x | y;
            3'd7:    res = ~x;
            default: res = 4'h0;
        endcase
    end
endmodule

// File: rtl/alu8_sequencer.sv
// 8-bit CPU ALU built from one nibble ALU used twice: low nibble, then high nibble.
module alu8_sequencer
    import alu8_pkg::*;
#(
    parameter bit HALF_CARRY_AND = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    alu8_sequencer_if.slave   bus
);
    state_e     state_r, state_s;
    logic [3:0] op_r;
    logic [7:0] a_r, b_r;
    logic [3:0] flags_r;
    logic [3:0] lo_res_r;
    logic       lo_cy_r, lo_zero_r;
    logic       busy_r, done_r, write_result_r;
    logic [7:0] result_r;
    logic [3:0] flags_out_r;

    nib_ctl_t   ctl_s;
    logic [3:0] alu_x_s, alu_y_s, alu_res_s;
    logic       alu_cout_s, z_s, write_s;
    logic [7:0] result_s;
    logic [3:0] flags_s;

    alu u_alu (
        .op   (ctl_s.op),
        .x    (alu_x_s),
        .y    (alu_y_s),
        .cin  (ctl_s.cin),
        .res  (alu_res_s),
        .cout (alu_cout_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (bus.start) state_s = ST_LOW; else state_s = ST_IDLE;
            ST_LOW:  state_s = ST_HIGH;
            ST_HIGH: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Nibble ALU operand mux and final 8-bit result/flag assembly for the high pass.
    always_comb begin
        ctl_s = nib_map(op_r, (state_r == ST_HIGH), flags_r[FLAG_C], lo_cy_r);
        if (state_r == ST_HIGH) begin
            alu_x_s = a_r[7:4];
            alu_y_s = b_r[7:4];
        end else begin
            alu_x_s = a_r[3:0];
            alu_y_s = b_r[3:0];
        end
        z_s      = lo_zero_r & (alu_res_s == 4'h0);
        result_s = {alu_res_s, lo_res_r};
        flags_s  = 4'h0;
        write_s  = 1'b1;
        case (op_r)
            OP_ADD, OP_ADC:        flags_s = {z_s, 1'b0, lo_cy_r, alu_cout_s};
            OP_SUB, OP_SBC:        flags_s = {z_s, 1'b1, lo_cy_r, alu_cout_s};
            OP_CP: begin
                flags_s = {z_s, 1'b1, lo_cy_r, alu_cout_s};
                write_s = 1'b0;
            end
            OP_AND:                flags_s = {z_s, 1'b0, HALF_CARRY_AND, 1'b0};
            OP_XOR, OP_OR:         flags_s = {z_s, 3'b000};
            OP_CPL:                flags_s = {flags_r[FLAG_Z], 1'b1, 1'b1, flags_r[FLAG_C]};
            default: begin
                result_s = a_r;
                flags_s  = flags_r;
                write_s  = 1'b0;
            end
        endcase
    end

    // Operand latch, low-pass intermediate and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r           <= 4'h0;
            a_r            <= 8'h00;
            b_r            <= 8'h00;
            flags_r        <= 4'h0;
            lo_res_r       <= 4'h0;
            lo_cy_r        <= 1'b0;
            lo_zero_r      <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            write_result_r <= 1'b0;
            result_r       <= 8'h00;
            flags_out_r    <= 4'h0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_r    <= bus.op;
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        flags_r <= bus.flags_in;
                        busy_r  <= 1'b1;
                    end
                end
                ST_LOW: begin
                    lo_res_r  <= alu_res_s;
                    lo_cy_r   <= alu_cout_s;
                    lo_zero_r <= (alu_res_s == 4'h0);
                end
                ST_HIGH: begin
                    result_r       <= result_s;
                    flags_out_r    <= flags_s;
                    write_result_r <= write_s;
                    done_r         <= 1'b1;
                    busy_r         <= 1'b0;
                end
                default: busy_r <= 1'b0;
            endcase
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.result       = result_r;
    assign bus.flags_out    = flags_out_r;
    assign bus.write_result = write_result_r;
endmodule

// File: tb/tb_alu8_sequencer.sv
// Directed plus random stimulus against a whole-byte arithmetic reference model.
module tb_alu8_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;

    alu8_sequencer_if bus ();

    alu8_sequencer #(.HALF_CARRY_AND(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    endtask

    // Returns {write_result, Z, N, H, C, result[7:0]}.
    function automatic logic [12:0] model(input int op, input int a, input int b, input logic [3:0] fl);
        int r, ci, h, c, n, w;
        logic [3:0] f;
        ci = int'(fl[0]);
        w = 1; h = 0; c = 0; n = 0; r = 0;
        case (op)
            0, 1: begin
                if (op == 0) ci = 0;
                r = a + b + ci;
                h = ((a % 16) + (b % 16) + ci > 15) ? 1 : 0;
                c = (r > 255) ? 1 : 0;
            end
            2, 3, 7: begin
                if (op != 3) ci = 0;
                r = a - b - ci;
                h = ((a % 16) < (b % 16) + ci) ? 1 : 0;
                c = (a < b + ci) ? 1 : 0;
                n = 1;
                if (op == 7) w = 0;
            end
            4: begin r = a & b; h = 1; end
            5: r = a ^ b;
            6: r = a | b;
            8: r = 255 - a;
            default: r = a;
        endcase
        r = r & 255;
        f = {(r == 0), n[0], h[0], c[0]};
        if (op == 8) f = {fl[3], 1'b1, 1'b1, fl[0]};
        if (op > 8) begin f = fl; w = 0; end
        return {w[0], f, r[7:0]};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] fl);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.flags_in = fl;
    endtask

    task automatic scramble();
        bus.start    = 1'b0;
        bus.op       = 4'($urandom);
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.flags_in = 4'($urandom);
    endtask

    task automatic expect_done(input string name, input logic [12:0] e);
        check({name, " done"}, {7'd0, bus.done}, 8'd1);
        check({name, " result"}, bus.result, e[7:0]);
        check({name, " flags"}, {4'd0, bus.flags_out}, {4'd0, e[11:8]});
        check({name, " wr"}, {7'd0, bus.write_result}, {7'd0, e[12]});
        check({name, " busy"}, {7'd0, bus.busy}, 8'd0);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] fl);
        logic [12:0] e;
        e = model(int'(op), int'(a), int'(b), fl);
        drive(op, a, b, fl);
        tick();
        scramble();
        check({name, " busy low"}, {7'd0, bus.busy}, 8'd1);
        check({name, " no done low"}, {7'd0, bus.done}, 8'd0);
        tick();
        check({name, " no done high"}, {7'd0, bus.done}, 8'd0);
        tick();
        expect_done(name, e);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 4'h0; bus.a = 8'h00; bus.b = 8'h00; bus.flags_in = 4'h0;
        tick();
        tick();
        reset = 1'b0;
        check("rst busy", {7'd0, bus.busy}, 8'd0);
        check("rst done", {7'd0, bus.done}, 8'd0);
        check("rst result", bus.result, 8'h00);
        check("rst flags", {4'd0, bus.flags_out}, 8'h00);
        check("rst wr", {7'd0, bus.write_result}, 8'd0);

        run_op("add", 4'd0, 8'h3A, 8'hC6, 4'h0);
        check("add literal", {bus.flags_out, 4'h0}, 8'hB0);
        run_op("sbc", 4'd3, 8'h10, 8'h01, 4'b0001);
        check("sbc literal", bus.result, 8'h0E);
        run_op("cp", 4'd7, 8'h42, 8'h42, 4'h0);
        check("cp literal", {bus.flags_out, 3'd0, bus.write_result}, 8'hC0);
        run_op("and", 4'd4, 8'hF0, 8'h0F, 4'h0);
        check("and literal", {bus.flags_out, 4'h0}, 8'hA0);
        run_op("cpl", 4'd8, 8'h35, 8'h00, 4'b1001);
        check("cpl literal", {bus.result}, 8'hCA);
        run_op("illegal", 4'd12, 8'h5A, 8'h33, 4'b0110);

        // start pulsed in LOW is ignored; start in the done cycle is accepted
        drive(4'd0, 8'h11, 8'h22, 4'h0);
        tick();
        drive(4'd5, 8'hFF, 8'hFF, 4'h0);
        tick();
        scramble();
        check("ign no done", {7'd0, bus.done}, 8'd0);
        tick();
        expect_done("ign", model(0, 32'h11, 32'h22, 4'h0));
        run_op("b2b adc", 4'd1, 8'hFF, 8'h00, 4'b0001);
        check("b2b literal", {bus.flags_out, 4'h0}, 8'hB0);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 4'($urandom_range(15, 0)), 8'($urandom), 8'($urandom), 4'($urandom));
        end

        // reset during the HIGH pass
        run_op("pre", 4'd2, 8'h00, 8'h01, 4'h0);
        drive(4'd0, 8'h01, 8'h01, 4'h0);
        tick();
        scramble();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid busy", {7'd0, bus.busy}, 8'd0);
        check("mid done", {7'd0, bus.done}, 8'd0);
        check("mid result", bus.result, 8'h00);
        check("mid flags", {4'd0, bus.flags_out}, 8'h00);
        tick();
        check("mid no late done", {7'd0, bus.done}, 8'd0);

        // reset beats a simultaneous start
        reset = 1'b1;
        drive(4'd0, 8'h01, 8'h02, 4'h0);
        tick();
        reset = 1'b0;
        scramble();
        check("rst+start busy", {7'd0, bus.busy}, 8'd0);
        tick();
        tick();
        check("rst+start no done", {7'd0, bus.done}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
